// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and double-dabble digit constants.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGIT_W   = 4;
  localparam int ADJ_THRESHOLD = 5;
  localparam int ADJ_ADD       = 3;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adj
);

  assign adj = (digit >= BCD_DIGIT_W'(ADJ_THRESHOLD)) ? digit + BCD_DIGIT_W'(ADJ_ADD)
                                                       : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one shift per clock. Result, blank mask
// and overflow are held stable between conversions to keep the display steady.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [W-1:0]                  bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic [DIGITS-1:0]             blank,
  output logic                          overflow
);

  localparam int BW = BCD_DIGIT_W * DIGITS;
  localparam int CW = $clog2(W + 1);

  state_t          state, state_nxt;
  logic [W-1:0]    bin_sr;
  logic [BW-1:0]   scratch;
  logic [BW-1:0]   scratch_adj;
  logic            ovf_s;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last_shift;
  logic [DIGITS-1:0] blank_nxt;
  logic            higher_zero;

  assign accept     = (state == IDLE) && start;
  assign last_shift = (cnt == CW'(W - 1));

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (scratch[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .adj   (scratch_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT) || (state == DONE);
  end

  // Shift datapath: adjusted scratch and binary register move left as one word;
  // the bit falling off the top digit means the value exceeds DIGITS digits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_sr  <= '0;
      scratch <= '0;
      ovf_s   <= 1'b0;
      cnt     <= '0;
    end else if (accept) begin
      bin_sr  <= bin;
      scratch <= '0;
      ovf_s   <= 1'b0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      scratch <= {scratch_adj[BW-2:0], bin_sr[W-1]};
      bin_sr  <= {bin_sr[W-2:0], 1'b0};
      ovf_s   <= ovf_s | scratch_adj[BW-1];
      cnt     <= cnt + CW'(1);
    end
  end

  // Digit i (i >= 1) is a leading zero when it and every digit above it are 0.
  always_comb begin
    blank_nxt   = '0;
    higher_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      higher_zero  = higher_zero && (scratch[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
      blank_nxt[i] = higher_zero;
    end
  end

  // Output registers: updated only on the edge that leaves DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      bcd      <= '0;
      blank    <= ~DIGITS'(1);
      overflow <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        bcd      <= scratch;
        blank    <= blank_nxt;
        overflow <= ovf_s;
      end
    end
  end

endmodule
